conv_frame_ctrl: RTL
====================

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 24, is the width of the pixel and feature words.
REQ-002 Parameter IMG_W, default 28, is the image width in pixels.
REQ-003 Parameter IMG_H, default 28, is the image height in pixels.
REQ-004 Parameter K, default 5, is the kernel size; IMG_W >= K and IMG_H >= K SHALL hold.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to process one frame.
REQ-008 pix_in  in  DATA_WIDTH  raster-order input pixel.
REQ-009 pix_valid  in  1  pix_in is valid.
REQ-010 pix_ready  out  1  controller accepts a pixel this cycle.
REQ-011 conv_data_in  out  DATA_WIDTH  pixel forwarded to the conv2d5x5 engine data_in.
REQ-012 conv_valid_in  out  1  strobe to the engine valid_in.
REQ-013 conv_data_out  in  DATA_WIDTH  engine result, one per forwarded pixel, in order.
REQ-014 conv_valid_out  in  1  engine result strobe.
REQ-015 feat_out  out  DATA_WIDTH  qualified feature-map word.
REQ-016 feat_valid  out  1  feat_out is valid.
REQ-017 busy  out  1  a frame is in progress.
REQ-018 done  out  1  one-cycle end-of-frame pulse.

Function
REQ-019 The FSM SHALL have the states IDLE, FEED, DRAIN and DONE.
REQ-020 In IDLE, start=1 SHALL move the FSM to FEED and clear the input counters (in_col, in_row) and the output counters (out_col, out_row).
REQ-021 pix_ready SHALL be 1 only in FEED; an accepted pixel is a cycle with pix_valid & pix_ready.
REQ-022 Each accepted pixel SHALL appear on conv_data_in with conv_valid_in=1 exactly one cycle later (registered); otherwise conv_valid_in=0 and conv_data_in holds its value.
REQ-023 On each accepted pixel, in_col SHALL increment; at IMG_W-1 it wraps to 0 and in_row increments.
REQ-024 The acceptance of pixel IMG_W*IMG_H-1 SHALL move the FSM to DRAIN, with pix_ready=0 from the next cycle.
REQ-025 In FEED and DRAIN, each conv_valid_out=1 SHALL advance out_col/out_row with the same wrap rule as the input counters.
REQ-026 A result SHALL be qualified when out_col >= K-1 and out_row >= K-1 (window fully inside the image).
REQ-027 A qualified result SHALL appear on feat_out with feat_valid=1 one cycle after its conv_valid_out; unqualified results SHALL produce feat_valid=0.
REQ-028 After the result with index IMG_W*IMG_H-1 is counted, the FSM SHALL enter DONE, whether it arrives in DRAIN or is still in FEED.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 busy SHALL be 1 in FEED and DRAIN and 0 in IDLE and DONE.
REQ-031 Exactly (IMG_W-K+1)*(IMG_H-K+1) feat_valid pulses SHALL occur per frame.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 conv_valid_out in IDLE or DONE SHALL be ignored and SHALL not change the counters.
REQ-034 A simultaneous pixel accept and conv_valid_out in one cycle SHALL update both counter sets independently.
REQ-035 pix_valid gaps (bubbles) SHALL stall the counters without loss or duplication.

Reset
REQ-036 rst=0 SHALL asynchronously force state IDLE, clear all counters, and drive pix_ready, conv_valid_in, feat_valid, busy and done to 0, with conv_data_in and feat_out at 0.
REQ-037 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait in IDLE for a new start.

Verification (IMG_W=IMG_H=6, K=5; engine model echoes its input 2 cycles later)
REQ-038 Reset then idle -> all outputs 0, pix_ready=0, and no feat_valid for any pix_valid activity.
REQ-039 start, then 36 back-to-back pixels valued 0..35 -> feat_out = 28, 29, 34, 35 (4 pulses), then a single done pulse, with busy falling in the same cycle done rises.
REQ-040 Same frame with pix_valid toggled every other cycle -> identical feat_out sequence, and pix_ready drops after the 36th accept.
REQ-041 start pulsed again during FEED -> no effect on the counters, and still exactly 4 feat_valid pulses.
REQ-042 rst asserted after 20 pixels, then a new start and a full frame -> exactly 4 correct outputs and one done, with no stale outputs.
REQ-043 Spurious conv_valid_out while IDLE, then a normal frame -> output values and count unchanged versus REQ-039.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame controller for a 5x5 conv2d engine: feeds one raster frame of pixels,
// counts engine results and forwards only those whose window lies fully inside the image.
module conv_frame_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int K          = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [DATA_WIDTH-1:0] conv_data_in,
    output logic                  conv_valid_in,
    input  logic [DATA_WIDTH-1:0] conv_data_out,
    input  logic                  conv_valid_out,
    output logic [DATA_WIDTH-1:0] feat_out,
    output logic                  feat_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_QUAL = CW'(K - 1);
    localparam logic [RW-1:0] ROW_QUAL = RW'(K - 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_inCol;
    logic [RW-1:0] r_inRow;
    logic [CW-1:0] r_outCol;
    logic [RW-1:0] r_outRow;

    logic w_accept;
    logic w_result;
    logic w_lastIn;
    logic w_lastOut;
    logic w_qual;

    // Results are only meaningful while a frame is active; strays in IDLE/DONE are dropped.
    assign w_accept  = pix_valid & (r_state == FEED);
    assign w_result  = conv_valid_out & ((r_state == FEED) | (r_state == DRAIN));
    assign w_lastIn  = (r_inCol == COL_LAST) & (r_inRow == ROW_LAST);
    assign w_lastOut = (r_outCol == COL_LAST) & (r_outRow == ROW_LAST);
    assign w_qual    = (r_outCol >= COL_QUAL) & (r_outRow >= ROW_QUAL);

    // Frame sequencing and both counter sets; status outputs are registered with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_inCol   <= '0;
            r_inRow   <= '0;
            r_outCol  <= '0;
            r_outRow  <= '0;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= FEED;
                        r_inCol   <= '0;
                        r_inRow   <= '0;
                        r_outCol  <= '0;
                        r_outRow  <= '0;
                        pix_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                FEED, DRAIN: begin
                    if (w_accept) begin
                        if (r_inCol == COL_LAST) begin
                            r_inCol <= '0;
                            r_inRow <= r_inRow + RW'(1);
                        end else begin
                            r_inCol <= r_inCol + CW'(1);
                        end
                        if (w_lastIn) begin
                            r_state   <= DRAIN;
                            pix_ready <= 1'b0;
                        end
                    end
                    // Final result wins over the FEED->DRAIN move if both land together.
                    if (w_result) begin
                        if (r_outCol == COL_LAST) begin
                            r_outCol <= '0;
                            r_outRow <= r_outRow + RW'(1);
                        end else begin
                            r_outCol <= r_outCol + CW'(1);
                        end
                        if (w_lastOut) begin
                            r_state   <= DONE;
                            pix_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle registered forwarding to the engine and out to the feature map.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_valid_in <= 1'b0;
            conv_data_in  <= '0;
            feat_valid    <= 1'b0;
            feat_out      <= '0;
        end else begin
            conv_valid_in <= w_accept;
            if (w_accept) begin
                conv_data_in <= pix_in;
            end
            feat_valid <= w_result & w_qual;
            if (w_result & w_qual) begin
                feat_out <= conv_data_out;
            end
        end
    end

endmodule
